spi_transaction_sequencer: RTL and testbench
============================================

// Module: spi_transaction_sequencer
// PURPOSE
//  Sequences complete transactions on generic_spi_controller from the AXI clock domain.
//  Each transaction runs these steps:
//   - accept a command (bit length);
//   - stream the TX words into controller memory;
//   - pulse spi_strb;
//   - wait for the serial transfer to finish;
//   - stream the captured RX words back out.
//  Firmware then issues one command plus two streams instead of bit-banging the pointers and strobe.
// PARAMETERS
//  MEM_DEPTH       64      controller memory depth in 32b words; must match the controller
//  TIMEOUT_CYCLES  65536   max axi_clk cycles in WAIT_START+WAIT_END before abort
// PORTS
//  axi_clk              in   1   clock; only clock, all logic rising-edge
//  axi_resetn           in   1   reset, asynchronous, active-low
//  cmd_valid            in   1   command offered
//  cmd_ready            out  1   command accepted when valid&ready
//  cmd_len              in   32  transaction length in bits, driven to controller spi_len
//  tx_data              in   32  TX word stream
//  tx_valid             in   1   TX word offered
//  tx_ready             out  1   TX word accepted when valid&ready
//  rx_data              out  32  RX word stream (= ctrl mem_read)
//  rx_valid             out  1   RX word available
//  rx_ready             in   1   RX word consumed when valid&ready
//  done                 out  1   1-cycle pulse at end of every accepted command
//  err                  out  2   0=ok 1=bad length 2=timeout; sticky until next cmd accept
//  busy                 out  1   state != IDLE
//  ctrl_mem_write       out  32  to controller mem_write (= tx_data)
//  ctrl_mem_write_strb  out  1   tx_valid & tx_ready
//  ctrl_mem_read        in   32  from controller mem_read
//  ctrl_mem_read_strb   out  1   rx_valid & rx_ready
//  ctrl_wptr_reset      out  1   to mem_write_ptr_reset
//  ctrl_rptr_reset      out  1   to mem_read_ptr_reset
//  ctrl_spi_len         out  32  latched cmd_len
//  ctrl_spi_strb        out  1   trigger pulse
//  ctrl_status          in   3   controller status {triggered, state[1:0]}
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except cmd_ready=1; counters, err and ctrl_spi_len cleared.
//  Reset mid-transaction abandons it. No flush is issued to the controller.
//  nwords = ceil(cmd_len/32) = cmd_len[31:5] + |cmd_len[4:0]; computed once at accept, 32b wide.
//  FSM:
//   - IDLE: cmd_ready=1. On cmd_valid, latch len and nwords, then:
//     - if cmd_len==0 or nwords>MEM_DEPTH: err=1, done pulse next cycle, stay IDLE;
//     - else: err=0, go to PTR_RST.
//   - PTR_RST, exactly 1 cycle: ctrl_wptr_reset=ctrl_rptr_reset=1, then WRITE.
//   - WRITE: tx_ready=1 until nwords words taken, word count k++. After the last word, go to TRIGGER.
//   - TRIGGER, 1 cycle: ctrl_spi_strb=1, timer cleared, then WAIT_START.
//   - WAIT_START: wait for ctrl_status[2]==1, then WAIT_END.
//   - WAIT_END: wait for ctrl_status==3'b000, i.e. the controller has left DONE and the trigger has cleared. Then READ.
//   - READ: rx_valid=1, rx_data=ctrl_mem_read, word count k++ per handshake. After nwords handshakes: done pulse, go IDLE.
//  Timeout: timer increments in WAIT_START and WAIT_END. At TIMEOUT_CYCLES: err=2, done pulse, go IDLE, skip READ.
//  RX readback is not offered on timeout.
//  ctrl_wptr_reset and ctrl_rptr_reset are never asserted with a strobe in the same cycle.
//  cmd_ready=0 in every non-IDLE state; cmd_valid is ignored there.
//  tx_valid is ignored outside WRITE. rx_ready is ignored outside READ.
//  Latency from command accept to first tx_ready is 2 cycles. After the last TX word, ctrl_spi_strb is asserted on the next cycle.
//  ctrl_spi_len holds the latched value from accept until the next accept.
// TESTING
//  1. cmd_len=40; TX 0xA5A5A5A5, 0x0000005A; controller stub loops pico->poci.
//     -> 2 write strobes, 1 spi_strb, RX = same 2 words, done, err=0.
//  2. cmd_len=0 -> no ctrl strobes, done 1 cycle after accept, err=1.
//     cmd_len=MEM_DEPTH*32+1 -> same response.
//  3. Controller status held at 0 after strobe.
//     -> done and err=2 at TIMEOUT_CYCLES+~3 cycles, no rx_valid.
//  4. tx_valid toggled every other cycle; rx_ready held low for 10 cycles.
//     -> no lost or duplicated words, mem strobes only on handshakes.
//  5. axi_resetn asserted during WAIT_END -> immediate IDLE, cmd_ready=1, err=0.
//     Next 32-bit command then completes normally.

Source files
------------

// File: rtl/spi_transaction_sequencer.sv
`default_nettype none
// =============================================================================
// Module : spi_transaction_sequencer
// Brief  : Runs command / TX stream / strobe / wait / RX stream transactions
//          against generic_spi_controller, all in the AXI clock domain.
// Rev    : 1.0  initial release
// =============================================================================
module spi_transaction_sequencer #(
   parameter int MEM_DEPTH      = 64,
   parameter int TIMEOUT_CYCLES = 65536
) (
   input  logic        axi_clk,
   input  logic        axi_resetn,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] cmd_len,
   input  logic [31:0] tx_data,
   input  logic        tx_valid,
   output logic        tx_ready,
   output logic [31:0] rx_data,
   output logic        rx_valid,
   input  logic        rx_ready,
   output logic        done,
   output logic [1:0]  err,
   output logic        busy,
   output logic [31:0] ctrl_mem_write,
   output logic        ctrl_mem_write_strb,
   input  logic [31:0] ctrl_mem_read,
   output logic        ctrl_mem_read_strb,
   output logic        ctrl_wptr_reset,
   output logic        ctrl_rptr_reset,
   output logic [31:0] ctrl_spi_len,
   output logic        ctrl_spi_strb,
   input  logic [2:0]  ctrl_status
);

   localparam int              C_TW          = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [31:0]     C_MEM_DEPTH   = 32'(MEM_DEPTH);
   localparam logic [C_TW-1:0] C_TIMER_LAST  = C_TW'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0]      C_ERR_OK      = 2'd0;
   localparam logic [1:0]      C_ERR_LEN     = 2'd1;
   localparam logic [1:0]      C_ERR_TIMEOUT = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_PTR_RST    = 3'd1,
      S_WRITE      = 3'd2,
      S_TRIGGER    = 3'd3,
      S_WAIT_START = 3'd4,
      S_WAIT_END   = 3'd5,
      S_READ       = 3'd6
   } state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic [31:0]     r_nwords;
   logic [31:0]     r_k;
   logic [31:0]     r_spi_len;
   logic [C_TW-1:0] r_timer;
   logic [1:0]      r_err;
   logic            r_done;

   logic [31:0]     w_cmd_nwords;
   logic            w_cmd_bad;
   logic            w_last_word;
   logic            w_timeout;
   logic            w_accept;
   logic            w_k_clr;
   logic            w_k_inc;
   logic            w_timer_clr;
   logic            w_timer_inc;
   logic            w_done_set;
   logic            w_err_load;
   logic [1:0]      w_err_val;

   // Word count rounds the bit length up to whole 32-bit words
   assign w_cmd_nwords = {5'd0, cmd_len[31:5]} + {31'd0, |cmd_len[4:0]};
   assign w_cmd_bad    = (cmd_len == 32'd0) || (w_cmd_nwords > C_MEM_DEPTH);
   assign w_last_word  = (r_k == (r_nwords - 32'd1));
   assign w_timeout    = (r_timer == C_TIMER_LAST);

   always_ff @(posedge axi_clk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next    = r_state;
      cmd_ready       = 1'b0;
      tx_ready        = 1'b0;
      rx_valid        = 1'b0;
      ctrl_wptr_reset = 1'b0;
      ctrl_rptr_reset = 1'b0;
      ctrl_spi_strb   = 1'b0;
      w_accept        = 1'b0;
      w_k_clr         = 1'b0;
      w_k_inc         = 1'b0;
      w_timer_clr     = 1'b0;
      w_timer_inc     = 1'b0;
      w_done_set      = 1'b0;
      w_err_load      = 1'b0;
      w_err_val       = C_ERR_OK;
      case (r_state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               w_accept   = 1'b1;
               w_err_load = 1'b1;
               w_k_clr    = 1'b1;
               if (w_cmd_bad) begin
                  w_err_val  = C_ERR_LEN;
                  w_done_set = 1'b1;
               end else begin
                  w_state_next = S_PTR_RST;
               end
            end
         end
         S_PTR_RST: begin
            ctrl_wptr_reset = 1'b1;
            ctrl_rptr_reset = 1'b1;
            w_state_next    = S_WRITE;
         end
         S_WRITE: begin
            tx_ready = 1'b1;
            if (tx_valid) begin
               if (w_last_word) begin
                  w_k_clr      = 1'b1;
                  w_state_next = S_TRIGGER;
               end else begin
                  w_k_inc = 1'b1;
               end
            end
         end
         S_TRIGGER: begin
            ctrl_spi_strb = 1'b1;
            w_timer_clr   = 1'b1;
            w_state_next  = S_WAIT_START;
         end
         S_WAIT_START, S_WAIT_END: begin
            w_timer_inc = 1'b1;
            // Abort wins over a same-cycle status change so the budget is hard
            if (w_timeout) begin
               w_err_load   = 1'b1;
               w_err_val    = C_ERR_TIMEOUT;
               w_done_set   = 1'b1;
               w_state_next = S_IDLE;
            end else if ((r_state == S_WAIT_START) && ctrl_status[2]) begin
               w_state_next = S_WAIT_END;
            end else if ((r_state == S_WAIT_END) && (ctrl_status == 3'b000)) begin
               w_state_next = S_READ;
            end
         end
         S_READ: begin
            rx_valid = 1'b1;
            if (rx_ready) begin
               if (w_last_word) begin
                  w_k_clr      = 1'b1;
                  w_done_set   = 1'b1;
                  w_state_next = S_IDLE;
               end else begin
                  w_k_inc = 1'b1;
               end
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge axi_clk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         r_nwords  <= 32'd0;
         r_k       <= 32'd0;
         r_spi_len <= 32'd0;
         r_timer   <= '0;
         r_err     <= C_ERR_OK;
         r_done    <= 1'b0;
      end else begin
         r_done <= w_done_set;
         if (w_accept) begin
            r_spi_len <= cmd_len;
            r_nwords  <= w_cmd_nwords;
         end
         if (w_err_load) begin
            r_err <= w_err_val;
         end
         if (w_k_clr) begin
            r_k <= 32'd0;
         end else if (w_k_inc) begin
            r_k <= r_k + 32'd1;
         end
         if (w_timer_clr) begin
            r_timer <= '0;
         end else if (w_timer_inc) begin
            r_timer <= r_timer + 1'b1;
         end
      end
   end

   // Data paths are gated so every output reads zero while idle
   assign ctrl_mem_write      = tx_ready ? tx_data : 32'd0;
   assign ctrl_mem_write_strb = tx_valid & tx_ready;
   assign rx_data             = rx_valid ? ctrl_mem_read : 32'd0;
   assign ctrl_mem_read_strb  = rx_valid & rx_ready;
   assign ctrl_spi_len        = r_spi_len;
   assign done                = r_done;
   assign err                 = r_err;
   assign busy                = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_transaction_sequencer.sv
`default_nettype none
// =============================================================================
// Module : tb_spi_transaction_sequencer
// Brief  : Randomized bench with a loopback controller stub and word scoreboard.
// Rev    : 1.0  initial release
// =============================================================================
module tb_spi_transaction_sequencer;

   localparam int MD = 16;
   localparam int TO = 200;

   logic        axi_clk = 1'b0;
   logic        axi_resetn = 1'b0;
   logic        cmd_valid, cmd_ready;
   logic [31:0] cmd_len;
   logic [31:0] tx_data;
   logic        tx_valid, tx_ready;
   logic [31:0] rx_data;
   logic        rx_valid, rx_ready;
   logic        done;
   logic [1:0]  err;
   logic        busy;
   logic [31:0] ctrl_mem_write;
   logic        ctrl_mem_write_strb;
   logic [31:0] ctrl_mem_read;
   logic        ctrl_mem_read_strb;
   logic        ctrl_wptr_reset, ctrl_rptr_reset;
   logic [31:0] ctrl_spi_len;
   logic        ctrl_spi_strb;
   logic [2:0]  ctrl_status;

   always #5 axi_clk = ~axi_clk;

   spi_transaction_sequencer #(.MEM_DEPTH(MD), .TIMEOUT_CYCLES(TO)) dut (
      .axi_clk(axi_clk), .axi_resetn(axi_resetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .done(done), .err(err), .busy(busy),
      .ctrl_mem_write(ctrl_mem_write), .ctrl_mem_write_strb(ctrl_mem_write_strb),
      .ctrl_mem_read(ctrl_mem_read), .ctrl_mem_read_strb(ctrl_mem_read_strb),
      .ctrl_wptr_reset(ctrl_wptr_reset), .ctrl_rptr_reset(ctrl_rptr_reset),
      .ctrl_spi_len(ctrl_spi_len), .ctrl_spi_strb(ctrl_spi_strb),
      .ctrl_status(ctrl_status)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Controller stub: loopback memory plus a scripted status sequence
   logic [31:0] stub_mem [MD];
   int  stub_wptr = 0, stub_rptr = 0;
   bit  stub_hang = 1'b0, stub_stall_end = 1'b0;
   int  st_t = -1, st_a = 0, st_b = 1;

   always @(posedge axi_clk) begin
      if (ctrl_wptr_reset) stub_wptr <= 0;
      else if (ctrl_mem_write_strb) begin
         stub_mem[stub_wptr % MD] <= ctrl_mem_write;
         stub_wptr <= stub_wptr + 1;
      end
      if (ctrl_rptr_reset) stub_rptr <= 0;
      else if (ctrl_mem_read_strb) stub_rptr <= stub_rptr + 1;
   end
   assign ctrl_mem_read = stub_mem[stub_rptr % MD];

   always @(posedge axi_clk or negedge axi_resetn) begin
      if (!axi_resetn) st_t <= -1;
      else if (ctrl_spi_strb && !stub_hang) begin
         st_t <= 0;
         st_a <= int'($urandom_range(0, 3));
         st_b <= int'($urandom_range(1, 6));
      end else if (st_t >= 0 && st_t < 1000) st_t <= st_t + 1;
   end

   always_comb begin
      ctrl_status = 3'b000;
      if (st_t < 0 || st_t < st_a)                        ctrl_status = 3'b000;
      else if (st_t < st_a + 2)                           ctrl_status = 3'b100;
      else if (stub_stall_end || st_t < st_a + 2 + st_b)  ctrl_status = 3'b101;
      else if (st_t < st_a + 3 + st_b)                    ctrl_status = 3'b110;
      else if (st_t < st_a + 4 + st_b)                    ctrl_status = 3'b010;
   end

   // Protocol monitor
   int mon_wr = 0, mon_rd = 0, mon_trig = 0, mon_viol = 0;
   always @(posedge axi_clk) begin
      if (ctrl_mem_write_strb) mon_wr <= mon_wr + 1;
      if (ctrl_mem_read_strb)  mon_rd <= mon_rd + 1;
      if (ctrl_spi_strb)       mon_trig <= mon_trig + 1;
      if (((ctrl_wptr_reset || ctrl_rptr_reset) &&
           (ctrl_spi_strb || ctrl_mem_write_strb || ctrl_mem_read_strb)) ||
          (ctrl_mem_write_strb !== (tx_valid && tx_ready)) ||
          (ctrl_mem_read_strb  !== (rx_valid && rx_ready)) ||
          (cmd_ready === busy))
         mon_viol <= mon_viol + 1;
   end

   logic [31:0] fixed_q[$];

   task automatic run_cmd(input logic [31:0] len, input bit tx_toggle, input int rx_hold, input bit hang);
      logic [63:0] nw;
      bit          bad, seen_done, seen_rx;
      logic [31:0] sent_q[$];
      int          wr0, rd0, tr0, cyc, sent, got, rcyc;
      nw  = (64'(len) + 64'd31) / 64'd32;
      bad = (len == 32'd0) || (nw > 64'(MD));
      stub_hang = hang;
      @(negedge axi_clk);
      wr0 = mon_wr; rd0 = mon_rd; tr0 = mon_trig;
      check_value("cmd_ready_idle", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_len   = len;
      @(negedge axi_clk);
      cmd_valid = 1'b0;
      cmd_len   = $urandom;
      check_value("spi_len_latched", ctrl_spi_len, len);
      if (bad) begin
         check_value("bad_done", done, 1);
         check_value("bad_err", err, 1);
         check_value("bad_busy", busy, 0);
         @(negedge axi_clk);
         check_value("bad_done_pulse", done, 0);
         check_value("bad_no_strobes", (mon_wr - wr0) + (mon_rd - rd0) + (mon_trig - tr0), 0);
         return;
      end
      check_value("ptr_reset_cycle", {ctrl_wptr_reset, ctrl_rptr_reset, tx_ready}, 3'b110);
      @(negedge axi_clk);
      check_value("tx_ready_latency", tx_ready, 1);
      sent = 0; cyc = 0;
      while (sent < nw && cyc < 4 * MD + 10) begin
         tx_valid = tx_toggle ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
         tx_data  = (sent < fixed_q.size()) ? fixed_q[sent] : $urandom;
         if (tx_valid && tx_ready) begin
            sent_q.push_back(tx_data);
            sent++;
         end
         @(negedge axi_clk);
         cyc++;
      end
      tx_valid = ($urandom_range(0, 1) != 0);
      tx_data  = $urandom;
      check_value("tx_words_taken", sent, nw);
      check_value("trigger_after_last", ctrl_spi_strb, 1);
      check_value("tx_ready_dropped", tx_ready, 0);
      cyc = 0; seen_done = 0; seen_rx = 0; got = 0; rcyc = 0;
      while (!seen_done && cyc < TO + 200) begin
         if (done) seen_done = 1;
         else begin
            if (rx_valid) begin
               seen_rx  = 1;
               rx_ready = (rcyc >= rx_hold) && ($urandom_range(0, 3) != 0);
               rcyc++;
               if (rx_ready) begin
                  if (sent_q.size() == 0) check_value("rx_extra_word", 1, 0);
                  else check_value("rx_word", rx_data, sent_q.pop_front());
                  got++;
               end
            end else begin
               rx_ready = ($urandom_range(0, 1) != 0);
            end
            @(negedge axi_clk);
            cyc++;
         end
      end
      rx_ready = 1'b0;
      tx_valid = 1'b0;
      check_value("done_seen", seen_done, 1);
      if (hang) begin
         check_value("timeout_err", err, 2);
         check_value("timeout_no_rx", seen_rx, 0);
         check_value("timeout_latency", (cyc >= TO) && (cyc <= TO + 3), 1);
         check_value("timeout_no_rd", mon_rd - rd0, 0);
      end else begin
         check_value("ok_err", err, 0);
         check_value("rx_count", got, nw);
         check_value("wr_strobes", mon_wr - wr0, nw);
         check_value("rd_strobes", mon_rd - rd0, nw);
      end
      check_value("one_trigger", mon_trig - tr0, 1);
      @(negedge axi_clk);
      check_value("done_pulse_width", done, 0);
      check_value("idle_after_done", busy, 0);
   endtask

   task automatic reset_mid_wait();
      int cyc;
      stub_hang = 1'b0;
      stub_stall_end = 1'b1;
      @(negedge axi_clk);
      cmd_valid = 1'b1;
      cmd_len   = 32'd64;
      @(negedge axi_clk);
      cmd_valid = 1'b0;
      cyc = 0;
      while (ctrl_status != 3'b101 && cyc < 100) begin
         tx_valid = 1'b1;
         tx_data  = $urandom;
         @(negedge axi_clk);
         cyc++;
      end
      tx_valid = 1'b0;
      repeat (3) @(negedge axi_clk);
      check_value("pre_reset_busy", busy, 1);
      axi_resetn = 1'b0;
      #1;
      check_value("rst_cmd_ready", cmd_ready, 1);
      check_value("rst_busy", busy, 0);
      check_value("rst_err", err, 0);
      check_value("rst_spi_len", ctrl_spi_len, 0);
      @(negedge axi_clk);
      axi_resetn = 1'b1;
      stub_stall_end = 1'b0;
      run_cmd(32'd32, 1'b0, 0, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      cmd_valid = 1'b0; cmd_len = 32'd0; tx_data = 32'hDEADBEEF;
      tx_valid = 1'b1; rx_ready = 1'b1;
      repeat (3) @(negedge axi_clk);
      check_value("reset_ctrl", {cmd_ready, busy, tx_ready, rx_valid, done}, 5'b10000);
      check_value("reset_err", err, 0);
      check_value("reset_spi_len", ctrl_spi_len, 0);
      check_value("reset_data", {rx_data, ctrl_mem_write}, 64'd0);
      check_value("reset_strobes",
                  {ctrl_mem_write_strb, ctrl_mem_read_strb, ctrl_wptr_reset, ctrl_rptr_reset, ctrl_spi_strb}, 5'b0);
      tx_valid = 1'b0; rx_ready = 1'b0;
      axi_resetn = 1'b1;

      fixed_q = '{32'hA5A5A5A5, 32'h0000005A};
      run_cmd(32'd40, 1'b0, 0, 1'b0);
      fixed_q.delete();
      run_cmd(32'd0, 1'b0, 0, 1'b0);
      run_cmd(32'(MD * 32 + 1), 1'b0, 0, 1'b0);
      run_cmd(32'hFFFF_FFFF, 1'b0, 0, 1'b0);
      run_cmd(32'(MD * 32), 1'b0, 0, 1'b0);
      run_cmd(32'd64, 1'b0, 0, 1'b1);
      run_cmd(32'd200, 1'b1, 10, 1'b0);
      reset_mid_wait();
      for (int i = 0; i < 12; i++) begin
         run_cmd(32'($urandom_range(1, MD * 32 + 40)), ($urandom_range(0, 1) != 0),
                 int'($urandom_range(0, 5)), 1'b0);
      end
      @(negedge axi_clk);
      check_value("protocol_violations", mon_viol, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
